// File: rtl/uart_tx_scheduler_pkg.sv
// Purpose: shared types and helpers for the UART transmit scheduler.
//   - UART_WORD_LENGTH : default data bits per UART frame
//   - state_e          : scheduler FSM state encoding (3-bit)
//   - rr_index         : modular index helper used by arbiter and pointer update
package uart_tx_scheduler_pkg;

   localparam int unsigned UART_WORD_LENGTH = 8;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LATCH   = 3'd1,
      ST_START   = 3'd2,
      ST_WAIT_HI = 3'd3,
      ST_WAIT_LO = 3'd4,
      ST_DONE    = 3'd5
   } state_e;

   // (base + offset) mod n, used for round-robin walking and pointer advance
   function automatic int unsigned rr_index(input int unsigned base,
                                            input int unsigned offset,
                                            input int unsigned n);
      return (base + offset) % n;
   endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Purpose: combinational round-robin pick of one requester.
// Ports:
//   req         in  N_REQ  pending requests
//   ptr         in  ID_W   highest-priority index for this pick
//   any_c       out 1      at least one request pending
//   winner_id_c out ID_W   index of the first set bit at or after ptr (wrapping)
//   winner_oh_c out N_REQ  one-hot form of winner_id_c (zero when none)
module uart_tx_scheduler_rr_arbiter
   import uart_tx_scheduler_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned ID_W  = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic             any_c,
   output logic [ID_W-1:0]  winner_id_c,
   output logic [N_REQ-1:0] winner_oh_c
);

   int unsigned idx;

   // Walk from ptr upward, wrapping, and keep the first pending request
   always_comb begin
      any_c       = 1'b0;
      winner_id_c = '0;
      winner_oh_c = '0;
      idx         = 0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         idx = rr_index(32'(ptr), k, N_REQ);
         if (!any_c && ((req & (N_REQ'(1) << idx)) != '0)) begin
            any_c       = 1'b1;
            winner_id_c = ID_W'(idx);
         end
      end
      if (any_c) begin
         winner_oh_c = N_REQ'(1) << winner_id_c;
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Purpose: shares one UART transmitter among N_REQ requesters with round-robin
// arbitration, byte latching, Transmit pulse generation and frame tracking.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   req/req_data   level requests and per-requester bytes
//   ack/done       one-hot 1-cycle pulses: byte latched / frame finished or aborted
//   grant_id/busy  current owner and activity flag
//   tx_error       sticky start-timeout flag, cleared by clr_error
//   uart_datatx, uart_transmit, uart_tx_flag  UART TX interface
module uart_tx_scheduler
   import uart_tx_scheduler_pkg::*;
#(
   parameter int unsigned WORD_LENGTH   = UART_WORD_LENGTH,
   parameter int unsigned N_REQ         = 4,
   parameter int unsigned ID_W          = 2,
   parameter int unsigned START_TIMEOUT = 15
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [N_REQ-1:0]             req,
   input  logic [N_REQ*WORD_LENGTH-1:0] req_data,
   output logic [N_REQ-1:0]             ack,
   output logic [N_REQ-1:0]             done,
   output logic [ID_W-1:0]              grant_id,
   output logic                         busy,
   output logic                         tx_error,
   input  logic                         clr_error,
   output logic [WORD_LENGTH-1:0]       uart_datatx,
   output logic                         uart_transmit,
   input  logic                         uart_tx_flag
);

   localparam int unsigned    CNT_W   = $clog2(START_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(START_TIMEOUT);

   state_e                 state_q, state_d;
   logic [ID_W-1:0]        ptr_q, ptr_d;
   logic [ID_W-1:0]        grant_q, grant_d;
   logic [WORD_LENGTH-1:0] data_q, data_d;
   logic [N_REQ-1:0]       ack_q, ack_d;
   logic [N_REQ-1:0]       done_q, done_d;
   logic                   busy_q, busy_d;
   logic                   err_q, err_d;
   logic                   xmit_q, xmit_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;

   logic                   arb_any_c;
   logic [ID_W-1:0]        arb_id_c;
   logic [N_REQ-1:0]       arb_oh_c;
   logic [CNT_W-1:0]       cnt_inc_c;
   logic                   err_set_c;

   uart_tx_scheduler_rr_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_arb (
      .req         (req),
      .ptr         (ptr_q),
      .any_c       (arb_any_c),
      .winner_id_c (arb_id_c),
      .winner_oh_c (arb_oh_c)
   );

   // Next-state and registered-output computation; outputs take effect on state entry
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      grant_d   = grant_q;
      data_d    = data_q;
      ack_d     = '0;
      done_d    = '0;
      busy_d    = busy_q;
      xmit_d    = 1'b0;
      cnt_d     = cnt_q;
      err_set_c = 1'b0;
      cnt_inc_c = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

      case (state_q)
         ST_IDLE: begin
            busy_d = 1'b0;
            if (arb_any_c) begin
               state_d = ST_LATCH;
               grant_d = arb_id_c;
               data_d  = WORD_LENGTH'(req_data >> (32'(arb_id_c) * WORD_LENGTH));
               ack_d   = arb_oh_c;
               busy_d  = 1'b1;
               ptr_d   = ID_W'(rr_index(32'(arb_id_c), 1, N_REQ));
            end
         end
         ST_LATCH: begin
            state_d = ST_START;
            xmit_d  = 1'b1;
         end
         ST_START: begin
            state_d = ST_WAIT_HI;
            cnt_d   = '0;
         end
         ST_WAIT_HI: begin
            if (uart_tx_flag) begin
               state_d = ST_WAIT_LO;
            end else begin
               cnt_d = cnt_inc_c;
               // Frame never started: abort and report
               if (cnt_inc_c == CNT_TO) begin
                  err_set_c = 1'b1;
                  done_d    = N_REQ'(1) << grant_q;
                  busy_d    = 1'b0;
                  state_d   = ST_IDLE;
               end
            end
         end
         ST_WAIT_LO: begin
            if (!uart_tx_flag) begin
               state_d = ST_DONE;
               done_d  = N_REQ'(1) << grant_q;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase

      // A timeout in the same cycle as clr_error keeps the flag set
      err_d = err_set_c ? 1'b1 : (clr_error ? 1'b0 : err_q);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         data_q  <= '0;
         ack_q   <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         xmit_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         data_q  <= data_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
         xmit_q  <= xmit_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ack           = ack_q;
   assign done          = done_q;
   assign grant_id      = grant_q;
   assign busy          = busy_q;
   assign tx_error      = err_q;
   assign uart_datatx   = data_q;
   assign uart_transmit = xmit_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Testbench for uart_tx_scheduler: directed scenarios with a simple UART model
// that raises TX_flag two cycles after Transmit and holds it for 100 cycles.
module tb_uart_tx_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  ack;
   logic [3:0]  done;
   logic [1:0]  grant_id;
   logic        busy;
   logic        tx_error;
   logic        clr_error;
   logic [7:0]  uart_datatx;
   logic        uart_transmit;
   logic        uart_tx_flag;

   int passed = 0;
   int total  = 0;
   int tx_pulses = 0;

   bit model_en = 1'b1;
   int dly;
   int hold;

   uart_tx_scheduler #(
      .WORD_LENGTH   (8),
      .N_REQ         (4),
      .ID_W          (2),
      .START_TIMEOUT (15)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .req           (req),
      .req_data      (req_data),
      .ack           (ack),
      .done          (done),
      .grant_id      (grant_id),
      .busy          (busy),
      .tx_error      (tx_error),
      .clr_error     (clr_error),
      .uart_datatx   (uart_datatx),
      .uart_transmit (uart_transmit),
      .uart_tx_flag  (uart_tx_flag)
   );

   always #5 clk = ~clk;

   // UART model: flag rises two cycles after Transmit, stays high 100 cycles
   always @(posedge clk) begin
      if (reset) begin
         uart_tx_flag <= 1'b0;
         dly          <= 0;
         hold         <= 0;
      end else if (uart_transmit && model_en) begin
         dly <= 1;
      end else if (dly == 1) begin
         dly          <= 0;
         uart_tx_flag <= 1'b1;
         hold         <= 99;
      end else if (uart_tx_flag) begin
         if (hold == 0) uart_tx_flag <= 1'b0;
         else           hold <= hold - 1;
      end
   end

   always @(posedge clk) begin
      if (uart_transmit === 1'b1) tx_pulses <= tx_pulses + 1;
   end

   task automatic wait_ack(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (ack !== 4'b0000) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         if (done !== 4'b0000) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; req = '0; req_data = '0; clr_error = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (ack !== 4'b0)            $display("FAIL rst_ack got=%b exp=0000", ack); else passed++;
      total++; if (done !== 4'b0)           $display("FAIL rst_done got=%b exp=0000", done); else passed++;
      total++; if (grant_id !== 2'd0)       $display("FAIL rst_grant got=%0d exp=0", grant_id); else passed++;
      total++; if (busy !== 1'b0)           $display("FAIL rst_busy got=%b exp=0", busy); else passed++;
      total++; if (tx_error !== 1'b0)       $display("FAIL rst_err got=%b exp=0", tx_error); else passed++;
      total++; if (uart_datatx !== 8'h00)   $display("FAIL rst_data got=%h exp=00", uart_datatx); else passed++;
      total++; if (uart_transmit !== 1'b0)  $display("FAIL rst_xmit got=%b exp=0", uart_transmit); else passed++;
      reset = 1'b0;
      @(posedge clk); #1;
      total++; if (busy !== 1'b0 || ack !== 4'b0) $display("FAIL idle_quiet got busy=%b ack=%b exp=0/0000", busy, ack); else passed++;
   endtask

   task automatic test_fairness;
      bit ok;
      int id;
      logic [3:0] oh;
      logic [7:0] byt;
      req_data = 32'h44332211;
      req = 4'b1111;
      for (int f = 0; f < 8; f++) begin
         id  = f % 4;
         oh  = 4'(1) << id;
         byt = 8'((id + 1) * 17);
         if (f == 0) begin
            wait_ack(ok);
            total++; if (!ok) $display("FAIL t2_ack_timeout got=none exp=ack"); else passed++;
         end else begin
            @(posedge clk); #1;
            total++; if (ack !== 4'b0 || busy !== 1'b0) $display("FAIL t2_gap f=%0d got ack=%b busy=%b exp=0000/0", f, ack, busy); else passed++;
            @(posedge clk); #1;
         end
         total++; if (ack !== oh)        $display("FAIL t2_ack f=%0d got=%b exp=%b", f, ack, oh); else passed++;
         total++; if (grant_id !== 2'(id)) $display("FAIL t2_grant f=%0d got=%0d exp=%0d", f, grant_id, id); else passed++;
         total++; if (uart_datatx !== byt) $display("FAIL t2_data f=%0d got=%h exp=%h", f, uart_datatx, byt); else passed++;
         if (f == 7) req = 4'b0000;
         wait_done(ok);
         total++; if (!ok || done !== oh) $display("FAIL t2_done f=%0d got=%b exp=%b", f, done, oh); else passed++;
      end
   endtask

   task automatic test_single;
      bit ok;
      int p0;
      @(posedge clk); #1;
      req_data[7:0] = 8'hA5;
      req = 4'b0001;
      p0 = tx_pulses;
      @(posedge clk); #1;
      total++; if (ack !== 4'b0001)     $display("FAIL t1_ack got=%b exp=0001", ack); else passed++;
      total++; if (busy !== 1'b1)       $display("FAIL t1_busy got=%b exp=1", busy); else passed++;
      total++; if (uart_transmit !== 1'b0) $display("FAIL t1_xmit_early got=%b exp=0", uart_transmit); else passed++;
      req = 4'b0000;
      @(posedge clk); #1;
      total++; if (uart_transmit !== 1'b1) $display("FAIL t1_xmit got=%b exp=1", uart_transmit); else passed++;
      total++; if (uart_datatx !== 8'hA5)  $display("FAIL t1_data got=%h exp=a5", uart_datatx); else passed++;
      @(posedge clk); #1;
      total++; if (uart_transmit !== 1'b0) $display("FAIL t1_xmit_pulse got=%b exp=0", uart_transmit); else passed++;
      wait_done(ok);
      total++; if (!ok || done !== 4'b0001) $display("FAIL t1_done got=%b exp=0001", done); else passed++;
      total++; if (uart_tx_flag !== 1'b0 || busy !== 1'b1) $display("FAIL t1_done_cycle got flag=%b busy=%b exp=0/1", uart_tx_flag, busy); else passed++;
      @(posedge clk); #1;
      total++; if (busy !== 1'b0 || done !== 4'b0) $display("FAIL t1_after got busy=%b done=%b exp=0/0000", busy, done); else passed++;
      total++; if (tx_pulses - p0 !== 1) $display("FAIL t1_pulses got=%0d exp=1", tx_pulses - p0); else passed++;
   endtask

   task automatic test_wrap;
      bit ok;
      req = 4'b0010;
      wait_ack(ok);
      total++; if (!ok || ack !== 4'b0010) $display("FAIL t3_pre_ack got=%b exp=0010", ack); else passed++;
      req = 4'b0000;
      wait_done(ok);
      req = 4'b1010;
      wait_ack(ok);
      total++; if (!ok || ack !== 4'b1000 || grant_id !== 2'd3) $display("FAIL t3_first got ack=%b id=%0d exp=1000/3", ack, grant_id); else passed++;
      req[3] = 1'b0;
      wait_done(ok);
      wait_ack(ok);
      total++; if (!ok || ack !== 4'b0010 || grant_id !== 2'd1) $display("FAIL t3_wrap got ack=%b id=%0d exp=0010/1", ack, grant_id); else passed++;
      req = 4'b0000;
      wait_done(ok);
      req = 4'b1111;
      wait_ack(ok);
      total++; if (!ok || grant_id !== 2'd2) $display("FAIL t3_ptr got id=%0d exp=2", grant_id); else passed++;
      req = 4'b0000;
      wait_done(ok);
   endtask

   task automatic test_timeout;
      bit ok;
      int early;
      model_en = 1'b0;
      req_data[7:0] = 8'h5A;
      req = 4'b0001;
      wait_ack(ok);
      req = 4'b0000;
      @(posedge clk); #1;
      total++; if (uart_transmit !== 1'b1) $display("FAIL t4_xmit got=%b exp=1", uart_transmit); else passed++;
      early = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (done !== 4'b0 || tx_error !== 1'b0) early++;
      end
      total++; if (early !== 0) $display("FAIL t4_early got=%0d exp=0", early); else passed++;
      @(posedge clk); #1;
      total++; if (tx_error !== 1'b1)   $display("FAIL t4_err got=%b exp=1", tx_error); else passed++;
      total++; if (done !== 4'b0001)    $display("FAIL t4_done got=%b exp=0001", done); else passed++;
      @(posedge clk); #1;
      total++; if (busy !== 1'b0 || tx_error !== 1'b1) $display("FAIL t4_busy_sticky got busy=%b err=%b exp=0/1", busy, tx_error); else passed++;
      clr_error = 1'b1;
      @(posedge clk); #1;
      total++; if (tx_error !== 1'b0) $display("FAIL t4_clr got=%b exp=0", tx_error); else passed++;
      // clr_error held through a second timeout: set must win on that cycle
      req = 4'b0001;
      wait_ack(ok);
      req = 4'b0000;
      wait_done(ok);
      total++; if (!ok || tx_error !== 1'b1) $display("FAIL t4_set_wins got=%b exp=1", tx_error); else passed++;
      @(posedge clk); #1;
      total++; if (tx_error !== 1'b0) $display("FAIL t4_clr_after got=%b exp=0", tx_error); else passed++;
      clr_error = 1'b0;
      model_en = 1'b1;
   endtask

   task automatic test_reset_midframe;
      bit ok;
      req = 4'b0010;
      wait_ack(ok);
      total++; if (!ok || ack !== 4'b0010) $display("FAIL t5_ack got=%b exp=0010", ack); else passed++;
      req = 4'b0000;
      repeat (12) @(posedge clk);
      #1;
      total++; if (busy !== 1'b1) $display("FAIL t5_busy_pre got=%b exp=1", busy); else passed++;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      total++; if (busy !== 1'b0 || done !== 4'b0 || ack !== 4'b0) $display("FAIL t5_rst got busy=%b done=%b ack=%b exp=0/0000/0000", busy, done, ack); else passed++;
      total++; if (grant_id !== 2'd0 || uart_datatx !== 8'h00 || uart_transmit !== 1'b0) $display("FAIL t5_rst_out got id=%0d data=%h xmit=%b exp=0/00/0", grant_id, uart_datatx, uart_transmit); else passed++;
      req = 4'b0101;
      @(posedge clk); #1;
      total++; if (ack !== 4'b0001 || done !== 4'b0) $display("FAIL t5_ptr0 got ack=%b done=%b exp=0001/0000", ack, done); else passed++;
      req[0] = 1'b0;
      wait_done(ok);
      total++; if (!ok || done !== 4'b0001) $display("FAIL t5_done0 got=%b exp=0001", done); else passed++;
      wait_ack(ok);
      total++; if (!ok || ack !== 4'b0100) $display("FAIL t5_ack2 got=%b exp=0100", ack); else passed++;
      req = 4'b0000;
      wait_done(ok);
      total++; if (!ok || done !== 4'b0100) $display("FAIL t5_done2 got=%b exp=0100", done); else passed++;
   endtask

   task automatic test_ignored_inputs;
      bit ok;
      int acks;
      req_data[7:0] = 8'h3C;
      req = 4'b0001;
      wait_ack(ok);
      total++; if (!ok || ack !== 4'b0001) $display("FAIL t6_ack got=%b exp=0001", ack); else passed++;
      req = 4'b0000;
      req_data[7:0] = 8'hFF;
      @(posedge clk); #1;
      total++; if (uart_transmit !== 1'b1 || uart_datatx !== 8'h3C) $display("FAIL t6_xmit got xmit=%b data=%h exp=1/3c", uart_transmit, uart_datatx); else passed++;
      repeat (5) @(posedge clk);
      #1;
      req[1] = 1'b1;
      @(posedge clk); #1;
      req[1] = 1'b0;
      acks = 0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         if (ack !== 4'b0) acks++;
         if (done !== 4'b0) break;
      end
      total++; if (done !== 4'b0001) $display("FAIL t6_done got=%b exp=0001", done); else passed++;
      total++; if (uart_datatx !== 8'h3C) $display("FAIL t6_data_hold got=%h exp=3c", uart_datatx); else passed++;
      repeat (6) begin
         @(posedge clk); #1;
         if (ack !== 4'b0) acks++;
      end
      total++; if (acks !== 0) $display("FAIL t6_no_ack got=%0d exp=0", acks); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL t6_idle got=%b exp=0", busy); else passed++;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_fairness();
      test_single();
      test_wrap();
      test_timeout();
      test_reset_midframe();
      test_ignored_inputs();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
